// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch stage.
// Widths here describe the default 32-bit configuration of fetch_unit.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;

    typedef logic [0:0] fetchState_t;
    localparam fetchState_t IDLE = 1'b0;
    localparam fetchState_t RUN  = 1'b1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetchEntry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with clear; head word is visible combinationally.
// Used both as the prefetch buffer and as the in-flight request PC queue.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         pushData,
    input  logic                     pop,
    output logic [WIDTH-1:0]         headData,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic             doPush;
    logic             doPop;

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign doPop    = pop && !empty;
    assign doPush   = push && (!full || doPop);
    assign headData = mem[rdPtr];

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + PTR_W'(1);
            if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
            count <= count + CNT_W'(doPush) - CNT_W'(doPop);
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= pushData;
    end

    assert property (@(posedge clk) disable iff (!rst_n)
        !(push && full && !pop && !clear));

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, issues in-order imem requests under a credit limit,
// buffers returned words and hands one registered instruction per cycle to decode.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                 ADDR_W     = 32,
    parameter int                 INSTR_W    = 32,
    parameter int                 FIFO_DEPTH = 2,
    parameter logic [ADDR_W-1:0]  RESET_PC   = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic                imem_ready,
    input  logic                imem_rvalid,
    input  logic [INSTR_W-1:0]  imem_rdata,
    input  logic                stall,
    input  logic                redirect_valid,
    input  logic [ADDR_W-1:0]   redirect_pc,
    output logic [INSTR_W-1:0]  instruction,
    output logic                instr_valid,
    output logic [ADDR_W-1:0]   instr_pc
);

    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int ENTRY_W = ADDR_W + INSTR_W;

    fetchState_t               state;
    logic [ADDR_W-1:0]         pc;
    logic [CNT_W-1:0]          outstanding;
    logic [CNT_W-1:0]          outstandingNext;
    logic [CNT_W-1:0]          dropCnt;
    logic                      handshake;
    logic                      dropRsp;
    logic                      rspPush;
    logic                      popOut;

    logic [ENTRY_W-1:0]        pfHead;
    logic [CNT_W-1:0]          pfCount;
    logic                      pfFull;
    logic                      pfEmpty;

    logic [ADDR_W-1:0]         rspPc;
    logic [CNT_W-1:0]          pcqCount;
    logic                      pcqFull;
    logic                      pcqEmpty;

    // Every issued request reserves a buffer slot until its word leaves the FIFO.
    assign imem_req        = (state == RUN) && ((outstanding + pfCount) < CNT_W'(FIFO_DEPTH));
    assign imem_addr       = pc;
    assign handshake       = imem_req && imem_ready;
    assign dropRsp         = imem_rvalid && (dropCnt != '0);
    assign rspPush         = imem_rvalid && (dropCnt == '0) && !redirect_valid;
    assign popOut          = !redirect_valid && !stall && !pfEmpty;
    assign outstandingNext = outstanding + CNT_W'(handshake) - CNT_W'(imem_rvalid);

    fetch_fifo #(.WIDTH(ADDR_W), .DEPTH(FIFO_DEPTH)) pcQueue (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (redirect_valid),
        .push     (handshake && !redirect_valid),
        .pushData (pc),
        .pop      (rspPush),
        .headData (rspPc),
        .count    (pcqCount),
        .full     (pcqFull),
        .empty    (pcqEmpty)
    );

    fetch_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) prefetchFifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (redirect_valid),
        .push     (rspPush),
        .pushData ({rspPc, imem_rdata}),
        .pop      (popOut),
        .headData (pfHead),
        .count    (pfCount),
        .full     (pfFull),
        .empty    (pfEmpty)
    );

    // A redirect retires every request already sent: their responses are counted off in dropCnt.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            outstanding <= '0;
            dropCnt     <= '0;
            instruction <= INSTR_W'(NOP_INSTR);
            instr_valid <= 1'b0;
            instr_pc    <= '0;
        end else begin
            if (state == IDLE) state <= RUN;
            outstanding <= outstandingNext;
            if (redirect_valid) begin
                pc          <= redirect_pc;
                dropCnt     <= outstandingNext;
                instruction <= INSTR_W'(NOP_INSTR);
                instr_valid <= 1'b0;
            end else begin
                if (handshake) pc <= pc + ADDR_W'(PC_STEP);
                if (dropRsp) dropCnt <= dropCnt - CNT_W'(1);
                if (!stall) begin
                    if (!pfEmpty) begin
                        {instr_pc, instruction} <= pfHead;
                        instr_valid             <= 1'b1;
                    end else begin
                        instruction <= INSTR_W'(NOP_INSTR);
                        instr_valid <= 1'b0;
                    end
                end
            end
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n) (rspPush && !popOut) |-> !pfFull);
    assert property (@(posedge clk) disable iff (!rst_n) (handshake && !redirect_valid) |-> !pcqFull);
    assert property (@(posedge clk) disable iff (!rst_n) rspPush |-> !pcqEmpty);
    assert property (@(posedge clk) disable iff (!rst_n) (pcqCount + dropCnt) == outstanding);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand-written corner sequences and a random
// run against a queue-level reference model, with an in-order variable-latency memory.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int DEPTH = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req, instr_valid;
    logic [31:0] imem_addr, instruction, instr_pc;

    logic        wRst = 1'b0;
    logic        wReq, wValid;
    logic [31:0] wAddr, wInstr, wPc;

    fetch_unit #(.ADDR_W(32), .INSTR_W(32), .FIFO_DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instruction(instruction), .instr_valid(instr_valid), .instr_pc(instr_pc)
    );

    fetch_unit #(.ADDR_W(32), .INSTR_W(32), .FIFO_DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFFC)) dutWrap (
        .clk(clk), .rst_n(wRst), .imem_req(wReq), .imem_addr(wAddr),
        .imem_ready(1'b1), .imem_rvalid(1'b0), .imem_rdata(32'h0),
        .stall(1'b0), .redirect_valid(1'b0), .redirect_pc(32'h0),
        .instruction(wInstr), .instr_valid(wValid), .instr_pc(wPc)
    );

    int nVectors = 0;
    int nMiscompares = 0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } memReq_t;
    memReq_t memQ[$];
    int      edgeNo = 0;
    int      lastDue = 0;
    int      memLat = 1;

    logic [31:0] mPc, mInstr, mIpc;
    logic        mValid, mRun;
    int          mOut, mDrop;
    fetchEntry_t mFifo[$];
    logic [31:0] mPcq[$];

    typedef struct {
        logic        rst;
        logic        stl;
        logic        rdy;
        logic        expReq;
        logic [31:0] expAddr;
        logic        expValid;
        logic [31:0] expInstr;
        logic [31:0] expPc;
    } vec_t;
    vec_t vecs[13];

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return ((a >> 2) + 32'd1) * 32'h11;
    endfunction

    function automatic logic modelReq();
        return mRun && ((mOut + mFifo.size()) < DEPTH);
    endfunction

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVectors++;
        if (act !== exp) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic reportTimeout(input string name);
        nVectors++;
        nMiscompares++;
        $display("[TB] FAIL %s: timed out waiting for DUT", name);
    endtask

    // Reference behaviour for one clock edge, from the pre-edge model state and current inputs.
    task automatic modelStep();
        logic        req, hs;
        fetchEntry_t head;
        logic [31:0] p;
        if (!rst_n) begin
            mPc = 32'h0; mFifo.delete(); mPcq.delete(); mOut = 0; mDrop = 0; mRun = 1'b0;
            mInstr = 32'h0; mValid = 1'b0; mIpc = 32'h0;
        end else begin
            req = modelReq();
            hs  = req && imem_ready;
            if (redirect_valid) begin
                mOut = mOut + int'(hs) - int'(imem_rvalid);
                mDrop = mOut;
                mFifo.delete();
                mPcq.delete();
                mPc = redirect_pc;
                mInstr = 32'h0;
                mValid = 1'b0;
            end else begin
                if (!stall) begin
                    if (mFifo.size() > 0) begin
                        head = mFifo.pop_front();
                        mInstr = head.instr; mIpc = head.pc; mValid = 1'b1;
                    end else begin
                        mInstr = 32'h0; mValid = 1'b0;
                    end
                end
                if (imem_rvalid) begin
                    mOut--;
                    if (mDrop > 0) mDrop--;
                    else if (mPcq.size() > 0) begin
                        p = mPcq.pop_front();
                        mFifo.push_back('{pc: p, instr: memWord(p)});
                    end
                end
                if (hs) begin
                    mPcq.push_back(mPc);
                    mOut++;
                    mPc = mPc + 32'd4;
                end
            end
            mRun = 1'b1;
        end
    endtask

    task automatic checkOutput();
        checkValue("instruction", instruction, mInstr);
        checkValue("instr_valid", 32'(instr_valid), 32'(mValid));
        checkValue("instr_pc", instr_pc, mIpc);
        checkValue("imem_req", 32'(imem_req), 32'(modelReq()));
        checkValue("imem_addr", imem_addr, mPc);
    endtask

    // Drives one cycle of inputs, steps memory and model across the edge, then compares.
    task automatic applyStimulus(input logic r, input logic s, input logic rd,
                                 input logic [31:0] rpc, input logic rdy);
        logic        dutHs;
        logic [31:0] hsAddr;
        int          due;
        rst_n = r; stall = s; redirect_valid = rd; redirect_pc = rpc; imem_ready = rdy;
        if (r && memQ.size() > 0 && memQ[0].due == edgeNo + 1) begin
            imem_rvalid = 1'b1;
            imem_rdata  = memWord(memQ[0].addr);
            void'(memQ.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        #1;
        dutHs  = r && imem_req && imem_ready;
        hsAddr = imem_addr;
        modelStep();
        @(posedge clk);
        #1;
        edgeNo++;
        if (!r) begin
            memQ.delete();
            lastDue = edgeNo;
        end else if (dutHs) begin
            due = edgeNo + memLat;
            if (due <= lastDue) due = lastDue + 1;
            memQ.push_back('{addr: hsAddr, due: due});
            lastDue = due;
        end
        checkOutput();
    endtask

    initial begin
        logic        found;
        logic        r, s, rd, rdy;
        logic [31:0] rpc;

        vecs[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00, 32'h00};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00, 32'h00};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h04, 1'b0, 32'h00, 32'h00};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h08, 1'b0, 32'h00, 32'h00};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h08, 1'b1, 32'h11, 32'h00};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h22, 32'h04};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h10, 1'b1, 32'h22, 32'h04};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h10, 1'b1, 32'h22, 32'h04};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h10, 1'b1, 32'h22, 32'h04};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 32'h33, 32'h08};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h14, 1'b1, 32'h44, 32'h0C};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h18, 1'b0, 32'h00, 32'h0C};
        vecs[12] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h18, 1'b1, 32'h55, 32'h10};

        memLat = 1;
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].stl, 1'b0, 32'h0, vecs[i].rdy);
            checkValue($sformatf("vec%0d_req", i), 32'(imem_req), 32'(vecs[i].expReq));
            checkValue($sformatf("vec%0d_addr", i), imem_addr, vecs[i].expAddr);
            checkValue($sformatf("vec%0d_valid", i), 32'(instr_valid), 32'(vecs[i].expValid));
            checkValue($sformatf("vec%0d_instr", i), instruction, vecs[i].expInstr);
            checkValue($sformatf("vec%0d_pc", i), instr_pc, vecs[i].expPc);
        end

        // Memory not ready: request and address hold, decode sees bubbles once the buffer drains.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
            checkValue("notready_req", 32'(imem_req), 32'd1);
            checkValue("notready_addr", imem_addr, 32'h18);
            if (i > 0) checkValue("notready_valid", 32'(instr_valid), 32'd0);
        end

        // Redirect under stall with two long-latency requests in flight.
        memLat = 3;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (mOut == 2) found = 1'b1;
            else applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        end
        if (!found) reportTimeout("inflight_two");
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h100, 1'b1);
        checkValue("redirect_valid_low", 32'(instr_valid), 32'd0);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
            if (instr_valid) found = 1'b1;
        end
        if (!found) reportTimeout("redirect_first_valid");
        else begin
            checkValue("redirect_first_pc", instr_pc, 32'h100);
            checkValue("redirect_first_instr", instruction, 32'h451);
        end

        // Fill the buffer under stall, then reset mid-stream.
        memLat = 1;
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        checkValue("midreset_instr", instruction, 32'h0);
        checkValue("midreset_valid", 32'(instr_valid), 32'd0);
        checkValue("midreset_pc", instr_pc, 32'h0);
        checkValue("midreset_req", 32'(imem_req), 32'd0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        checkValue("postreset_req", 32'(imem_req), 32'd1);

        // Randomised traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            if (i % 50 == 0) memLat = int'($urandom_range(1, 4));
            r   = ($urandom_range(0, 99) != 0);
            s   = ($urandom_range(0, 99) < 30);
            rd  = ($urandom_range(0, 99) < 5);
            rdy = ($urandom_range(0, 99) < 70);
            rpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_0FFC);
            applyStimulus(r, s, rd, rpc, rdy);
        end

        // PC wrap on the second instance while the main one sits in reset.
        wRst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        checkValue("wrap_reset_addr", wAddr, 32'hFFFF_FFFC);
        checkValue("wrap_reset_req", 32'(wReq), 32'd0);
        wRst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        checkValue("wrap_first_addr", wAddr, 32'hFFFF_FFFC);
        checkValue("wrap_first_req", 32'(wReq), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        checkValue("wrap_second_addr", wAddr, 32'h0000_0000);
        checkValue("wrap_valid", 32'(wValid), 32'd0);
        checkValue("wrap_instr", wInstr, 32'h0);
        checkValue("wrap_instr_pc", wPc, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
